// File: rtl/apb_master_bridge_if.sv
// Request/response handshake plus the two-slave APB bus of the bridge.
// The master modport is the bridge side; the slave modport is the
// requester-plus-memories side seen by whatever drives the bridge.
interface apb_master_bridge_if #(
  parameter int ADD_WIDTH = 9,
  parameter int WIDTH     = 32
);
  // request side
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [ADD_WIDTH-1:0]   req_addr;
  logic [WIDTH-1:0]       req_wdata;
  logic [WIDTH/8-1:0]     req_strb;
  // response side
  logic                   rsp_valid;
  logic [WIDTH-1:0]       rsp_rdata;
  logic                   rsp_err;
  // APB bus to the two slaves
  logic                   Psel1;
  logic                   Psel2;
  logic                   Penable;
  logic                   Pwrite;
  logic [WIDTH/8-1:0]     Pstrb;
  logic [ADD_WIDTH-2:0]   Paddr;
  logic [WIDTH-1:0]       Pwdata;
  logic                   Pready1;
  logic                   Pready2;
  logic [WIDTH-1:0]       Prdata1;
  logic [WIDTH-1:0]       Prdata2;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    input  Pready1, Pready2, Prdata1, Prdata2,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output Psel1, Psel2, Penable, Pwrite, Pstrb, Paddr, Pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    output Pready1, Pready2, Prdata1, Prdata2,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  Psel1, Psel2, Penable, Pwrite, Pstrb, Paddr, Pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB master bridge: turns one valid/ready request into an APB SETUP/ACCESS
// transfer on Slave 1 or Slave 2 (chosen by the address MSB), then returns a
// one-cycle response. Reads take an extra RDCAP cycle because the slaves
// register their read data on the completing ACCESS edge.
module apb_master_bridge #(
  parameter int ADD_WIDTH = 9,
  parameter int WIDTH     = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                Pclk,
  input  logic                Presetn,
  apb_master_bridge_if.master bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort fires on the edge that would see the TIMEOUT-th low Pready.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RDCAP} state_t;

  state_t        state;
  logic          sel2;      // latched slave select, survives into RDCAP
  logic [CW-1:0] wait_cnt;
  logic          rdy;

  // Only the addressed slave's ready is ever looked at.
  assign rdy = sel2 ? bus.Pready2 : bus.Pready1;

  // Acceptance is combinational so it is visible straight out of reset.
  assign bus.req_ready = (state == IDLE) && Presetn;

  // Transfer FSM; every bus and response output is a register.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state         <= IDLE;
      sel2          <= 1'b0;
      wait_cnt      <= '0;
      bus.Psel1     <= 1'b0;
      bus.Psel2     <= 1'b0;
      bus.Penable   <= 1'b0;
      bus.Pwrite    <= 1'b0;
      bus.Pstrb     <= '0;
      bus.Paddr     <= '0;
      bus.Pwdata    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      // response is a single-cycle pulse; data/err are zero outside it
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            sel2       <= bus.req_addr[ADD_WIDTH-1];
            wait_cnt   <= '0;
            bus.Psel1  <= ~bus.req_addr[ADD_WIDTH-1];
            bus.Psel2  <= bus.req_addr[ADD_WIDTH-1];
            bus.Penable<= 1'b0;
            bus.Pwrite <= bus.req_write;
            bus.Paddr  <= bus.req_addr[ADD_WIDTH-2:0];
            // reads drive zero data and strobes
            bus.Pwdata <= bus.req_write ? bus.req_wdata : '0;
            bus.Pstrb  <= bus.req_write ? bus.req_strb  : '0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          bus.Penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (rdy || (TIMEOUT != 0 && wait_cnt == CNT_LAST)) begin
            bus.Psel1   <= 1'b0;
            bus.Psel2   <= 1'b0;
            bus.Penable <= 1'b0;
            bus.Pwrite  <= 1'b0;
            bus.Pstrb   <= '0;
            bus.Paddr   <= '0;
            bus.Pwdata  <= '0;
            if (!rdy) begin
              // timed out: error response, no data
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              state         <= IDLE;
            end else if (bus.Pwrite) begin
              bus.rsp_valid <= 1'b1;
              state         <= IDLE;
            end else begin
              state <= RDCAP;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RDCAP: begin
          bus.rsp_rdata <= sel2 ? bus.Prdata2 : bus.Prdata1;
          bus.rsp_valid <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with two behavioural memory slaves
// (registered read data, programmable wait states or a permanent stall).
module tb_apb_master_bridge;
  logic Pclk = 1'b0;
  logic Presetn = 1'b0;
  always #5 Pclk = ~Pclk;

  apb_master_bridge_if #(.ADD_WIDTH(9), .WIDTH(32)) bus();

  apb_master_bridge #(.ADD_WIDTH(9), .WIDTH(32), .TIMEOUT(16)) dut (
    .Pclk(Pclk), .Presetn(Presetn), .bus(bus)
  );

  int vecs = 0;
  int errs = 0;

  // ---------------- slave models ----------------
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  int   waits1 = 0, waits2 = 0;
  logic hold1 = 1'b0, hold2 = 1'b0;
  int   acc1 = 0, acc2 = 0;

  assign bus.Pready1 = !hold1 && (acc1 >= waits1);
  assign bus.Pready2 = !hold2 && (acc2 >= waits2);

  always @(posedge Pclk) begin
    logic [31:0] w;
    acc1 <= (bus.Psel1 && bus.Penable && !bus.Pready1) ? acc1 + 1 : 0;
    acc2 <= (bus.Psel2 && bus.Penable && !bus.Pready2) ? acc2 + 1 : 0;
    if (bus.Psel1 && bus.Penable && bus.Pready1) begin
      if (bus.Pwrite) begin
        w = mem1[bus.Paddr];
        for (int b = 0; b < 4; b++) if (bus.Pstrb[b]) w[b*8 +: 8] = bus.Pwdata[b*8 +: 8];
        mem1[bus.Paddr] <= w;
      end else bus.Prdata1 <= mem1[bus.Paddr];
    end
    if (bus.Psel2 && bus.Penable && bus.Pready2) begin
      if (bus.Pwrite) begin
        w = mem2[bus.Paddr];
        for (int b = 0; b < 4; b++) if (bus.Pstrb[b]) w[b*8 +: 8] = bus.Pwdata[b*8 +: 8];
        mem2[bus.Paddr] <= w;
      end else bus.Prdata2 <= mem2[bus.Paddr];
    end
  end

  // both selects at once is never legal
  always @(negedge Pclk) begin
    if (Presetn && bus.Psel1 && bus.Psel2) begin
      errs++;
      $display("FAIL onehot: Psel1=1 Psel2=1, required at most one");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        hold;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;   // cycles from acceptance edge to the rsp_valid cycle
    int          exp_nsel;  // cycles with a Psel high
  } vec_t;

  vec_t tbl [17];
  vec_t ops [6];

  task automatic load(input vec_t v);
    bus.req_write = v.w;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_strb  = v.strb;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int cyc, selc, enc;
    logic got, s2, unstable, pw;
    logic [7:0] pa;
    logic [3:0] ps;
    logic [31:0] pd;
    waits1 = v.waits; waits2 = v.waits;
    hold1 = v.hold;   hold2 = v.hold;
    load(v);
    bus.req_valid = 1'b1;
    cyc = 0;
    while (!bus.req_ready && cyc < 50) begin @(posedge Pclk); #1; cyc++; end
    @(posedge Pclk); #1;
    // scramble the request: it must have been captured at acceptance
    bus.req_valid = 1'b0;
    bus.req_write = ~v.w;
    bus.req_addr  = ~v.addr;
    bus.req_wdata = ~v.wdata;
    bus.req_strb  = ~v.strb;
    cyc = 1; selc = 0; enc = 0; got = 1'b0; unstable = 1'b0;
    s2 = 1'b0; pa = '0; pw = 1'b0; ps = '0; pd = '0;
    while (!got && cyc < 100) begin
      if (bus.Psel1 || bus.Psel2) begin
        if (selc == 0) begin
          s2 = bus.Psel2; pa = bus.Paddr; pw = bus.Pwrite; ps = bus.Pstrb; pd = bus.Pwdata;
        end else if ({bus.Psel2, bus.Paddr, bus.Pwrite, bus.Pstrb, bus.Pwdata} != {s2, pa, pw, ps, pd})
          unstable = 1'b1;
        selc++;
      end
      if (bus.Penable) enc++;
      if (bus.rsp_valid) got = 1'b1;
      else begin @(posedge Pclk); #1; cyc++; end
    end
    chk({nm, "_got_rsp"}, 64'(got), 64'd1);
    chk({nm, "_latency"}, 64'(cyc), 64'(v.exp_lat));
    chk({nm, "_rdata"}, 64'(bus.rsp_rdata), 64'(v.exp_rd));
    chk({nm, "_err"}, 64'(bus.rsp_err), 64'(v.exp_err));
    chk({nm, "_psel_cycles"}, 64'(selc), 64'(v.exp_nsel));
    chk({nm, "_penable_cycles"}, 64'(enc), 64'(v.exp_nsel - 1));
    chk({nm, "_slave"}, 64'(s2), 64'(v.addr[8]));
    chk({nm, "_paddr"}, 64'(pa), 64'(v.addr[7:0]));
    chk({nm, "_pwrite"}, 64'(pw), 64'(v.w));
    chk({nm, "_pstrb"}, 64'(ps), 64'(v.w ? v.strb : 4'h0));
    chk({nm, "_pwdata"}, 64'(pd), 64'(v.w ? v.wdata : 32'h0));
    chk({nm, "_stable"}, 64'(unstable), 64'd0);
    chk({nm, "_idle_bus"}, 64'({bus.Psel1, bus.Psel2, bus.Penable, bus.req_ready}), 64'b0001);
    @(posedge Pclk); #1;
    chk({nm, "_rsp_pulse"}, 64'(bus.rsp_valid), 64'd0);
    hold1 = 1'b0; hold2 = 1'b0; waits1 = 0; waits2 = 0;
  endtask

  // ---------------- test ----------------
  initial begin
    int idx, t, nrsp, seen;
    logic accepted;
    int acc_t [6];
    logic [31:0] rsp_d [6];
    logic rsp_e [6];

    //             w     addr     wdata         strb wt hold exp_rd        err lat nsel
    tbl[0]  = '{1'b1, 9'h005, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0,        1'b0, 3, 2};
    tbl[1]  = '{1'b0, 9'h005, 32'h0,        4'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 4, 2};
    tbl[2]  = '{1'b1, 9'h105, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 32'h0,        1'b0, 3, 2};
    tbl[3]  = '{1'b1, 9'h105, 32'h00001234, 4'h3, 0, 1'b0, 32'h0,        1'b0, 3, 2};
    tbl[4]  = '{1'b0, 9'h105, 32'h0,        4'h0, 0, 1'b0, 32'hFFFF1234, 1'b0, 4, 2};
    tbl[5]  = '{1'b0, 9'h005, 32'h0,        4'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 4, 2};
    tbl[6]  = '{1'b1, 9'h0FF, 32'hCAFEF00D, 4'hF, 0, 1'b0, 32'h0,        1'b0, 3, 2};
    tbl[7]  = '{1'b0, 9'h0FF, 32'h0,        4'h0, 0, 1'b0, 32'hCAFEF00D, 1'b0, 4, 2};
    tbl[8]  = '{1'b1, 9'h100, 32'h87654321, 4'hF, 0, 1'b0, 32'h0,        1'b0, 3, 2};
    tbl[9]  = '{1'b0, 9'h100, 32'h0,        4'h0, 0, 1'b0, 32'h87654321, 1'b0, 4, 2};
    tbl[10] = '{1'b0, 9'h1FF, 32'h0,        4'h0, 0, 1'b1, 32'h0,        1'b1, 18, 17};
    tbl[11] = '{1'b1, 9'h0FF, 32'h00AB0000, 4'h4, 0, 1'b0, 32'h0,        1'b0, 3, 2};
    tbl[12] = '{1'b0, 9'h0FF, 32'h0,        4'h0, 0, 1'b0, 32'hCAABF00D, 1'b0, 4, 2};
    tbl[13] = '{1'b1, 9'h030, 32'h0F0F0F0F, 4'hF, 2, 1'b0, 32'h0,        1'b0, 5, 4};
    tbl[14] = '{1'b0, 9'h030, 32'h0,        4'h0, 3, 1'b0, 32'h0F0F0F0F, 1'b0, 7, 5};
    tbl[15] = '{1'b0, 9'h105, 32'h0,        4'h0, 0, 1'b0, 32'hFFFF1234, 1'b0, 4, 2};
    tbl[16] = '{1'b1, 9'h010, 32'h11111111, 4'hF, 0, 1'b0, 32'h0,        1'b0, 3, 2};

    ops[0] = '{1'b1, 9'h020, 32'hA5A5A5A5, 4'hF, 0, 1'b0, 32'h0,        1'b0, 0, 0};
    ops[1] = '{1'b1, 9'h121, 32'h0BADF00D, 4'hF, 0, 1'b0, 32'h0,        1'b0, 0, 0};
    ops[2] = '{1'b1, 9'h020, 32'h000000C3, 4'h1, 0, 1'b0, 32'h0,        1'b0, 0, 0};
    ops[3] = '{1'b1, 9'h123, 32'h12345678, 4'hF, 0, 1'b0, 32'h0,        1'b0, 0, 0};
    ops[4] = '{1'b0, 9'h020, 32'h0,        4'h0, 0, 1'b0, 32'hA5A5A5C3, 1'b0, 0, 0};
    ops[5] = '{1'b0, 9'h121, 32'h0,        4'h0, 0, 1'b0, 32'h0BADF00D, 1'b0, 0, 0};

    bus.req_valid = 1'b0;
    load(ops[0]);

    // reset state
    repeat (3) @(posedge Pclk);
    #1;
    chk("rst_ctl", 64'({bus.rsp_valid, bus.rsp_err, bus.Psel1, bus.Psel2, bus.Penable, bus.Pwrite, bus.req_ready}), 64'd0);
    chk("rst_addr_strb", 64'({bus.Pstrb, bus.Paddr}), 64'd0);
    chk("rst_pwdata", 64'(bus.Pwdata), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    Presetn = 1'b1;
    #1;
    chk("rst_release_ready", 64'(bus.req_ready), 64'd1);
    @(posedge Pclk); #1;

    // table of single transfers
    for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // back-to-back with req_valid held: 4 writes, 2 reads
    idx = 0; t = 0; nrsp = 0;
    load(ops[0]);
    bus.req_valid = 1'b1;
    while ((idx < 6 || nrsp < 6) && t < 200) begin
      if (bus.rsp_valid && nrsp < 6) begin
        rsp_d[nrsp] = bus.rsp_rdata; rsp_e[nrsp] = bus.rsp_err; nrsp++;
      end
      accepted = 1'b0;
      if (idx < 6 && bus.req_valid && bus.req_ready) begin
        acc_t[idx] = t; idx++; accepted = 1'b1;
      end
      @(posedge Pclk); #1; t++;
      if (accepted) begin
        if (idx < 6) load(ops[idx]);
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b_accepts", 64'(idx), 64'd6);
    chk("b2b_responses", 64'(nrsp), 64'd6);
    if (idx == 6 && nrsp == 6) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("b2b_gap%0d", i), 64'(acc_t[i+1] - acc_t[i]), 64'(i < 4 ? 3 : 4));
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("b2b_rdata%0d", i), 64'(rsp_d[i]), 64'(ops[i].exp_rd));
        chk($sformatf("b2b_err%0d", i), 64'(rsp_e[i]), 64'd0);
      end
    end
    @(posedge Pclk); #1;

    // reset asserted while a write to 0x010 is stalled in ACCESS
    hold1 = 1'b1;
    load('{1'b1, 9'h010, 32'h13579BDF, 4'hF, 0, 1'b0, 32'h0, 1'b0, 0, 0});
    bus.req_valid = 1'b1;
    @(posedge Pclk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge Pclk);
    #1;
    chk("mid_access", 64'({bus.Psel1, bus.Penable}), 64'b11);
    Presetn = 1'b0;
    #1;
    chk("mid_rst_bus", 64'({bus.Psel1, bus.Psel2, bus.Penable, bus.rsp_valid, bus.req_ready}), 64'd0);
    chk("mid_rst_data", 64'({bus.Paddr, bus.Pwdata}), 64'd0);
    @(posedge Pclk); #1;
    Presetn = 1'b1;
    hold1 = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge Pclk); #1;
      if (bus.rsp_valid || bus.Psel1 || bus.Psel2) seen++;
    end
    chk("post_rst_quiet", 64'(seen), 64'd0);
    run_vec('{1'b0, 9'h010, 32'h0, 4'h0, 0, 1'b0, 32'h11111111, 1'b0, 4, 2}, "post_rst_rd_old");
    run_vec('{1'b1, 9'h010, 32'h2468ACE0, 4'hF, 0, 1'b0, 32'h0, 1'b0, 3, 2}, "post_rst_wr");
    run_vec('{1'b0, 9'h010, 32'h0, 4'h0, 0, 1'b0, 32'h2468ACE0, 1'b0, 4, 2}, "post_rst_rd");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
